// File: rtl/tap_sample_encoder_pkg.sv
// ============================================================================
// Module : tap_pkg
// Brief  : Shared TAP v1 constants and FSM state types for the record path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tap_pkg;

    localparam logic [7:0] TAP_LONG_MARKER = 8'h00;
    localparam int         TAP_SHORT_MIN   = 8;
    localparam int         TAP_SHORT_MAX   = 2047;
    localparam int         TAP_LONG_W      = 24;

    typedef enum logic [2:0] {
        EM_IDLE,
        EM_SHORT,
        EM_L0,
        EM_L1,
        EM_L2,
        EM_L3
    } emit_state_t;

    typedef enum logic [1:0] {
        MS_OFF,
        MS_ARMED,
        MS_COUNT
    } meas_state_t;

    // Samples below 8 cycles would encode as 0x00, which collides with the long marker.
    function automatic logic is_short(input logic [TAP_LONG_W-1:0] s, input int short_max);
        return (s >= TAP_LONG_W'(TAP_SHORT_MIN)) && (s <= TAP_LONG_W'(short_max));
    endfunction

endpackage

`default_nettype wire

// File: rtl/tap_sample_encoder_if.sv
// ============================================================================
// Module : tap_sample_encoder_if
// Brief  : Valid/ack byte channel from the sample encoder to the tape-file sink.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tap_sample_encoder_if;
    logic [7:0] data;
    logic       data_valid;
    logic       ack;

    modport master (output data, output data_valid, input ack);
    modport slave  (input data, input data_valid, output ack);
endinterface

`default_nettype wire

// File: rtl/tap_sample_encoder_pulse_timer.sv
// ============================================================================
// Module : tap_pulse_timer
// Brief  : Synchronises the cassette write line and times falling-edge periods.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tap_pulse_timer
    import tap_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             cycle_tick,
    input  wire logic             record,
    input  wire logic             tape_write,
    output logic                  sample_stb,
    output logic [CNT_W-1:0]      sample,
    output logic                  arm_stb
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic              r_w0;
    logic              r_w1;
    logic              w_fall;
    meas_state_t       r_state;
    meas_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w0    <= 1'b0;
            r_w1    <= 1'b0;
            r_state <= MS_OFF;
            r_count <= '0;
        end else begin
            r_w0    <= tape_write;
            r_w1    <= r_w0;
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign w_fall = !r_w0 && r_w1;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        sample_stb  = 1'b0;
        arm_stb     = 1'b0;
        case (r_state)
            MS_OFF: begin
                w_count_nxt = '0;
                if (record) begin
                    w_state_nxt = MS_ARMED;
                    arm_stb     = 1'b1;
                end
            end
            MS_ARMED: begin
                if (!record) begin
                    w_state_nxt = MS_OFF;
                end else if (w_fall) begin
                    w_state_nxt = MS_COUNT;
                    w_count_nxt = '0;
                end
            end
            MS_COUNT: begin
                if (!record) begin
                    w_state_nxt = MS_OFF;
                    w_count_nxt = '0;
                end else if (w_fall) begin
                    // A tick landing on the edge belongs to the next pulse.
                    sample_stb  = 1'b1;
                    w_count_nxt = {{(CNT_W-1){1'b0}}, cycle_tick};
                end else if (cycle_tick) begin
                    if (r_count == C_CNT_MAX) begin
                        sample_stb  = 1'b1;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = MS_OFF;
                w_count_nxt = '0;
            end
        endcase
    end

    assign sample = r_count;

endmodule

`default_nettype wire

// File: rtl/tap_sample_encoder.sv
// ============================================================================
// Module : tap_sample_encoder
// Brief  : Converts cassette write-line pulse periods into a TAP v1 byte stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tap_sample_encoder
    import tap_pkg::*;
#(
    parameter int CNT_W     = 24,
    parameter int SHORT_MAX = TAP_SHORT_MAX
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              cycle_tick,
    input  wire logic              record,
    input  wire logic              tape_write,
    tap_sample_encoder_if.master   sink,
    output logic                   busy,
    output logic                   overrun
);

    logic                   w_stb;
    logic                   w_arm;
    logic [CNT_W-1:0]       w_sample;
    logic [TAP_LONG_W-1:0]  w_sample_ext;

    emit_state_t            r_state;
    emit_state_t            w_state_nxt;
    logic [TAP_LONG_W-1:0]  r_hold;
    logic [TAP_LONG_W-1:0]  w_hold_nxt;
    logic                   r_overrun;
    logic                   w_overrun_nxt;
    logic [7:0]             r_data;
    logic [7:0]             w_data_nxt;
    logic                   r_valid;
    logic                   w_free;

    tap_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .cycle_tick (cycle_tick),
        .record     (record),
        .tape_write (tape_write),
        .sample_stb (w_stb),
        .sample     (w_sample),
        .arm_stb    (w_arm)
    );

    generate
        if (CNT_W >= TAP_LONG_W) begin : g_ext_trunc
            assign w_sample_ext = w_sample[TAP_LONG_W-1:0];
        end else begin : g_ext_pad
            assign w_sample_ext = {{(TAP_LONG_W-CNT_W){1'b0}}, w_sample};
        end
    endgenerate

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_overrun_nxt = r_overrun;
        w_free        = 1'b0;
        w_data_nxt    = 8'h00;
        case (r_state)
            EM_IDLE:  w_free = 1'b1;
            EM_SHORT: if (sink.ack) begin w_state_nxt = EM_IDLE; w_free = 1'b1; end
            EM_L0:    if (sink.ack) w_state_nxt = EM_L1;
            EM_L1:    if (sink.ack) w_state_nxt = EM_L2;
            EM_L2:    if (sink.ack) w_state_nxt = EM_L3;
            EM_L3:    if (sink.ack) begin w_state_nxt = EM_IDLE; w_free = 1'b1; end
            default:  w_state_nxt = EM_IDLE;
        endcase

        if (w_arm) begin
            w_overrun_nxt = 1'b0;
        end
        // A handoff coinciding with the final ack is taken back-to-back.
        if (w_stb) begin
            if (w_free) begin
                w_hold_nxt  = w_sample_ext;
                w_state_nxt = is_short(w_sample_ext, SHORT_MAX) ? EM_SHORT : EM_L0;
            end else begin
                w_overrun_nxt = 1'b1;
            end
        end

        case (w_state_nxt)
            EM_SHORT: w_data_nxt = w_hold_nxt[10:3];
            EM_L0:    w_data_nxt = TAP_LONG_MARKER;
            EM_L1:    w_data_nxt = w_hold_nxt[7:0];
            EM_L2:    w_data_nxt = w_hold_nxt[15:8];
            EM_L3:    w_data_nxt = w_hold_nxt[23:16];
            default:  w_data_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= EM_IDLE;
            r_hold    <= '0;
            r_overrun <= 1'b0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_overrun <= w_overrun_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= (w_state_nxt != EM_IDLE);
        end
    end

    assign sink.data       = r_data;
    assign sink.data_valid = r_valid;
    assign busy            = (r_state != EM_IDLE);
    assign overrun         = r_overrun;

endmodule

`default_nettype wire
